// File: rtl/reg_read_port.sv
// Register bank with a request/valid/ready read port. A read returns a stable
// snapshot of the addressed entry, forwarding a same-edge write on the fetch cycle.
module reg_read_port #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              write_signal,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  input_value,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              read_accept,
  output logic              read_valid,
  input  logic              read_ready,
  output logic [WIDTH-1:0]  output_value,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  raddr_q;
  logic [WIDTH-1:0]   mem [DEPTH];

  assign read_accept = read_req & ((state_q == IDLE) | ((state_q == HOLD) & read_ready));
  assign read_valid  = (state_q == HOLD);
  assign busy        = (state_q != IDLE);

  // Writes run independently of the read FSM, even while a read is outstanding.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_signal) begin
      mem[write_addr] <= input_value;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_req) state_d = FETCH;
      FETCH:   state_d = HOLD;
      HOLD:    if (read_ready) state_d = read_req ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output_value only moves on the fetch edge; the array read would miss a
  // write landing on that same edge, so that write is forwarded instead.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      raddr_q      <= '0;
      output_value <= '0;
    end else begin
      state_q <= state_d;
      if (read_accept) begin
        raddr_q <= read_addr;
      end
      if (state_q == FETCH) begin
        if (write_signal && (write_addr == raddr_q)) begin
          output_value <= input_value;
        end else begin
          output_value <= mem[raddr_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Directed self-checking bench for reg_read_port: reset, basic read, bypass,
// hold stability, back-to-back throughput and asynchronous reset mid-read.
module tb_reg_read_port;

  logic        CLK;
  logic        RST;
  logic        write_signal;
  logic [2:0]  write_addr;
  logic [15:0] input_value;
  logic        read_req;
  logic [2:0]  read_addr;
  logic        read_accept;
  logic        read_valid;
  logic        read_ready;
  logic [15:0] output_value;
  logic        busy;

  int total = 0;
  int bad   = 0;

  reg_read_port dut (
    .CLK          (CLK),
    .RST          (RST),
    .write_signal (write_signal),
    .write_addr   (write_addr),
    .input_value  (input_value),
    .read_req     (read_req),
    .read_addr    (read_addr),
    .read_accept  (read_accept),
    .read_valid   (read_valid),
    .read_ready   (read_ready),
    .output_value (output_value),
    .busy         (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge CLK);
    write_signal = 1'b1;
    write_addr   = addr;
    input_value  = data;
    @(negedge CLK);
    write_signal = 1'b0;
  endtask

  // Full handshake from IDLE with read_ready high; returns at the negedge where
  // read_valid is seen, or reports ok = 0 when the cycle budget runs out.
  task automatic read_word(input logic [2:0] addr, output logic [15:0] data, output logic ok);
    @(negedge CLK);
    read_req   = 1'b1;
    read_addr  = addr;
    read_ready = 1'b1;
    @(negedge CLK);
    read_req = 1'b0;
    ok   = 1'b0;
    data = '0;
    for (int i = 0; i < 10; i++) begin
      if (read_valid === 1'b1) begin
        ok   = 1'b1;
        data = output_value;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        ok;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if (read_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", read_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if (output_value !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data: got %h expected 0000", output_value); end
    total++;
    if (read_accept !== 1'b0) begin bad++; $display("[TB] FAIL reset_accept: got %b expected 0", read_accept); end
    RST = 1'b1;
    read_word(3'd5, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 16'h0000) begin
      bad++; $display("[TB] FAIL reset_read5: got %h (ok=%b) expected 0000", d, ok);
    end
  endtask

  task automatic test_basic_read();
    do_write(3'd2, 16'hC5A0);
    read_req   = 1'b1;
    read_addr  = 3'd2;
    read_ready = 1'b1;
    #1;
    total++;
    if (read_accept !== 1'b1) begin bad++; $display("[TB] FAIL basic_accept: got %b expected 1", read_accept); end
    @(negedge CLK);
    read_req = 1'b0;
    total++;
    if (busy !== 1'b1 || read_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_fetch: got busy=%b valid=%b expected busy=1 valid=0", busy, read_valid);
    end
    @(negedge CLK);
    total++;
    if (read_valid !== 1'b1 || output_value !== 16'hC5A0) begin
      bad++; $display("[TB] FAIL basic_data: got valid=%b data=%h expected valid=1 data=c5a0", read_valid, output_value);
    end
    @(negedge CLK);
    total++;
    if (busy !== 1'b0 || read_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_idle: got busy=%b valid=%b expected 0 0", busy, read_valid);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] d;
    logic        ok;
    do_write(3'd7, 16'h1234);
    read_req   = 1'b1;
    read_addr  = 3'd7;
    read_ready = 1'b1;
    @(negedge CLK);
    read_req     = 1'b0;
    write_signal = 1'b1;
    write_addr   = 3'd7;
    input_value  = 16'hFFFF;
    @(negedge CLK);
    write_signal = 1'b0;
    total++;
    if (read_valid !== 1'b1 || output_value !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL bypass_data: got valid=%b data=%h expected valid=1 data=ffff", read_valid, output_value);
    end
    read_word(3'd7, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL bypass_stored: got %h (ok=%b) expected ffff", d, ok);
    end
  endtask

  task automatic test_hold_stability();
    @(negedge CLK);
    read_ready = 1'b0;
    do_write(3'd3, 16'h00AA);
    read_req  = 1'b1;
    read_addr = 3'd3;
    @(negedge CLK);
    read_req = 1'b0;
    @(negedge CLK);
    total++;
    if (read_valid !== 1'b1 || output_value !== 16'h00AA) begin
      bad++; $display("[TB] FAIL hold_first: got valid=%b data=%h expected valid=1 data=00aa", read_valid, output_value);
    end
    for (int i = 0; i < 5; i++) begin
      write_signal = (i == 0);
      write_addr   = 3'd3;
      input_value  = 16'h5555;
      read_req     = (i == 2);
      read_addr    = 3'd4;
      #1;
      total++;
      if (read_accept !== 1'b0) begin bad++; $display("[TB] FAIL hold_accept[%0d]: got %b expected 0", i, read_accept); end
      @(negedge CLK);
      total++;
      if (read_valid !== 1'b1 || output_value !== 16'h00AA) begin
        bad++; $display("[TB] FAIL hold_stable[%0d]: got valid=%b data=%h expected valid=1 data=00aa", i, read_valid, output_value);
      end
    end
    write_signal = 1'b0;
    read_req     = 1'b1;
    read_addr    = 3'd3;
    read_ready   = 1'b1;
    #1;
    total++;
    if (read_accept !== 1'b1) begin bad++; $display("[TB] FAIL hold_release_accept: got %b expected 1", read_accept); end
    @(negedge CLK);
    read_req = 1'b0;
    @(negedge CLK);
    total++;
    if (read_valid !== 1'b1 || output_value !== 16'h5555) begin
      bad++; $display("[TB] FAIL hold_next: got valid=%b data=%h expected valid=1 data=5555", read_valid, output_value);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int next_addr;
    int results;
    int last_cycle;
    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), 16'h1000 + 16'(i));
    end
    next_addr  = 0;
    results    = 0;
    last_cycle = 0;
    read_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && results < 8; cyc++) begin
      if (read_valid === 1'b1) begin
        total++;
        if (output_value !== 16'h1000 + 16'(results)) begin
          bad++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", results, output_value, 16'h1000 + 16'(results));
        end
        if (results > 0) begin
          total++;
          if (cyc - last_cycle != 2) begin
            bad++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected 2", results, cyc - last_cycle);
          end
        end
        last_cycle = cyc;
        results++;
      end
      read_req  = (next_addr < 8);
      read_addr = 3'(next_addr);
      #1;
      if (read_accept === 1'b1) next_addr++;
      @(negedge CLK);
    end
    read_req = 1'b0;
    total++;
    if (results != 8) begin bad++; $display("[TB] FAIL b2b_count: got %0d results expected 8", results); end
    @(negedge CLK);
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    logic        ok;
    do_write(3'd1, 16'hBEEF);
    read_req   = 1'b1;
    read_addr  = 3'd1;
    read_ready = 1'b0;
    @(negedge CLK);
    read_req = 1'b0;
    @(negedge CLK);
    total++;
    if (read_valid !== 1'b1 || output_value !== 16'hBEEF) begin
      bad++; $display("[TB] FAIL async_pre: got valid=%b data=%h expected valid=1 data=beef", read_valid, output_value);
    end
    #2;
    RST = 1'b0;
    #1;
    total++;
    if (read_valid !== 1'b0 || output_value !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL async_clear: got valid=%b data=%h busy=%b expected 0 0000 0", read_valid, output_value, busy);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    read_word(3'd1, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 16'h0000) begin bad++; $display("[TB] FAIL async_mem1: got %h (ok=%b) expected 0000", d, ok); end
    read_word(3'd2, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 16'h0000) begin bad++; $display("[TB] FAIL async_mem2: got %h (ok=%b) expected 0000", d, ok); end
    read_word(3'd7, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 16'h0000) begin bad++; $display("[TB] FAIL async_mem7: got %h (ok=%b) expected 0000", d, ok); end
    @(negedge CLK);
    read_ready = 1'b0;
  endtask

  initial begin
    RST          = 1'b0;
    write_signal = 1'b0;
    write_addr   = '0;
    input_value  = '0;
    read_req     = 1'b0;
    read_addr    = '0;
    read_ready   = 1'b0;
    test_reset();
    test_basic_read();
    test_bypass();
    test_hold_stability();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_read_port.md
# reg_read_port

Handshaked read side of the Double Accumulator Processor register storage. It holds a small bank of 16-bit registers written with the same single-cycle write_signal strobe as the existing Register block. Consumers (ALU operand fetch, debug readback) read it through a request/valid/ready handshake. The block returns a stable snapshot of the addressed register, forwarding a write to the fetched register on the fetch cycle.

## Interface
- WIDTH, 16, data width of every register
- DEPTH, 8, number of registers
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous and active-low: asserting RST low clears all state immediately, independent of CLK
- write_signal  in  1  write strobe; when high at a rising edge, the entry at write_addr is loaded with input_value
- write_addr  in  ADDR_W  write address
- input_value  in  WIDTH  write data
- read_req  in  1  read request; sampled with read_addr
- read_addr  in  ADDR_W  read address
- read_accept  out  1  combinational; high when read_req is taken at this edge
- read_valid  out  1  output_value holds read data
- read_ready  in  1  consumer takes the data this cycle
- output_value  out  WIDTH  read data, registered
- busy  out  1  high in any state other than IDLE

## Operation
- Storage: DEPTH x WIDTH array. Every entry is cleared to 0 by reset.
- Writes are independent of the read FSM. Writes occur on any cycle, including during an outstanding read.
- FSM states and transitions:
  - IDLE: read_valid = 0. If read_req = 1, accept, latch read_addr into raddr_q, go to FETCH.
  - FETCH: read_valid = 0. At the edge, load output_value from mem[raddr_q] and go to HOLD. Bypass: if write_signal = 1 and write_addr == raddr_q at the same edge, load input_value instead.
  - HOLD: read_valid = 1. output_value does not change, even if mem[raddr_q] is written.
    - read_ready = 1 and read_req = 1: accept the new request, latch its address, go to FETCH.
    - read_ready = 1 and read_req = 0: go to IDLE.
    - read_ready = 0: stay in HOLD. read_req is not accepted.
- read_accept = read_req & (state == IDLE | (state == HOLD & read_ready)).
- read_req in FETCH, or in HOLD without read_ready, is ignored. The requester holds read_req until read_accept.
- Only one read is outstanding at a time.
- Address range: all 2**ADDR_W addresses are valid, so there is no out-of-range case.
- Reset mid-operation: RST low from any state forces IDLE. It also forces read_valid = 0, output_value = 0, raddr_q = 0, and clears every storage entry. Any in-flight read is dropped with no response.

## Timing
- Reset values: read_valid = 0, busy = 0, output_value = 0, and every storage entry = 0. read_accept = 0 while read_req = 0.
- Read latency: a request accepted at edge N gives read_valid = 1 after edge N+1. Data is sampled at edge N+1.
- Write-then-read: a write at edge N is visible to a read whose FETCH edge is N or later. The FETCH-edge case goes through the bypass.
- Throughput: back-to-back reads with read_ready held high give one result every 2 cycles.
- output_value changes only at FETCH edges and on reset.
- Reset release: the first request can be accepted at the first rising edge after RST goes high.

## Test plan
- Reset: hold RST low, then release. Check read_valid = 0, busy = 0, output_value = 0x0000. A read of address 5 returns 0x0000.
- Basic read: write 0xC5A0 to address 2. Next cycle, request address 2 with read_ready = 1. read_valid rises after 2 edges with output_value = 0xC5A0. Return to IDLE.
- Bypass: request address 7. On the FETCH edge, write 0xFFFF to address 7 (old value 0x1234). output_value must be 0xFFFF.
- Hold stability: read address 3 (value 0x00AA) with read_ready = 0 for 5 cycles. Meanwhile write 0x5555 to address 3 and pulse read_req for address 4. output_value stays 0x00AA and read_accept stays 0. Raise read_ready with read_req for address 3: the next result is 0x5555.
- Back-to-back: addresses 0..7 preloaded with 0x1000+i, read_req and read_ready held high. Results appear in order, one every 2 cycles, 8 results total.
- Async reset mid-read: drop RST low in HOLD, between clock edges. read_valid and output_value go to 0 immediately without a clock edge. After release, the previously written addresses read 0x0000.
